regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised, scoreboarded register file for the datapath: two combinational read ports and one clocked write port, configurable data width and register count. It tracks a per-register busy bit so the control unit can detect pending results and stall. An optional write-to-read bypass lets a value being written be read in the same cycle. It sits between the decode stage (read, issue) and writeback (write, clear busy).

## Interface
- WIDTH, 8, data width in bits
- ABITS, 4, address width; register count DEPTH = 2^ABITS
- BYPASS, 1, 1 = same-cycle write forwarding to read ports; 0 = stored value only

- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- we3  input  1  write enable
- wa3  input  ABITS  write address
- wd3  input  WIDTH  write data
- ra1, ra2  input  ABITS  read addresses
- rd1, rd2  output  WIDTH  read data
- iss  input  1  issue strobe: mark register ia as pending
- ia  input  ABITS  issue (destination) address
- busy1, busy2  output  1  pending flag for ra1 / ra2
- pend_cnt  output  ABITS+1  number of registers currently busy (registered)

## Operation
- Register 0: reads always 0; writes to it ignored; never marked busy.
- Write: on rising clk with we3=1 and wa3!=0, regb[wa3] <= wd3 and busy[wa3] <= 0.
- Issue: on rising clk with iss=1 and ia!=0, busy[ia] <= 1.
- Same edge, we3 and iss to same nonzero address: data written, busy stays 1 (new producer pending).
- Same edge, different addresses: both take effect independently.
- Issue to an already-busy register: busy stays 1, pend_cnt unchanged.
- Write to a non-busy register: data written, busy stays 0, pend_cnt unchanged.
- pend_cnt always equals the popcount of busy[] after each edge; range 0..DEPTH-1.
- Read, BYPASS=1: if we3=1, wa3!=0 and wa3==raN, rdN = wd3 and busyN = 0; otherwise rdN = regb[raN], busyN = busy[raN]. raN=0 always gives rdN=0, busyN=0.
- Read, BYPASS=0: rdN = regb[raN], busyN = busy[raN]; written value visible the cycle after the edge.
- Both read ports may address the same register; both return identical values.

## Timing
- Reset (async, immediate, no clock needed): all regb = 0, all busy = 0, pend_cnt = 0; hence rd1 = rd2 = 0, busy1 = busy2 = 0.
- Reset asserted mid-operation overrides any write/issue on the same edge; state remains cleared while reset is high.
- First write/issue accepted on the first rising edge after reset deasserts.
- Reads: combinational, zero latency from raN, and (BYPASS=1) from we3/wa3/wd3.
- Write/issue latency: 1 cycle; stored data, busy and pend_cnt all update on the same edge.
- No handshake on write: every enabled edge is accepted; no backpressure.

## Test plan
- Reset: write 0xAA to r3, assert reset between edges -> rd1(ra1=3)=0x00, busy1=0, pend_cnt=0 immediately, without a clock edge.
- Write/read and r0: write 0x5C to r7 and 0xFF to r0 -> rd1(ra1=7)=0x5C, rd2(ra2=0)=0x00; write to r0 leaves every register unchanged.
- Bypass: BYPASS=1, we3=1, wa3=5, wd3=0x3E, ra1=5 before the edge -> rd1=0x3E, busy1=0 combinationally; with BYPASS=0 -> rd1 holds old value until after the edge.
- Scoreboard: issue r4 -> busy1(ra1=4)=1, pend_cnt=1; issue r4 again -> pend_cnt=1; write r4=0x11 -> busy1=0, pend_cnt=0, rd1=0x11.
- Collision: r9 busy, same edge we3 (wa3=9, wd3=0x42) and iss (ia=9) -> regb[9]=0x42, busy[9]=1, pend_cnt unchanged.
- Saturation: issue r1..r15 on consecutive edges -> pend_cnt=15; issue r0 -> pend_cnt=15; clear all by writes -> pend_cnt=0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports and one clocked
// write port. A per-register busy bit tracks pending results: issue sets it,
// writeback clears it. An optional bypass forwards the write port to the read
// ports in the same cycle. Register 0 is hard-wired to zero and is never busy.
module regfile_sb #(
    parameter int WIDTH  = 8,
    parameter int ABITS  = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [ABITS-1:0] wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [ABITS-1:0] ra1,
    input  logic [ABITS-1:0] ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             iss,
    input  logic [ABITS-1:0] ia,
    output logic             busy1,
    output logic             busy2,
    output logic [ABITS:0]   pend_cnt
);

    localparam int DEPTH = 1 << ABITS;

    logic [WIDTH-1:0] regb_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [ABITS:0]   pend_q;
    logic [ABITS:0]   pend_d;

    logic wr_en;
    logic is_en;

    // Writes and issues targeting register 0 are discarded.
    assign wr_en = we3 && (wa3 != '0);
    assign is_en = iss && (ia != '0);

    // Next busy vector: writeback clears first, issue then sets, so a same-edge
    // write and issue to one register leaves it pending on the new producer.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wa3] = 1'b0;
        end
        if (is_en) begin
            busy_d[ia] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Pending count is the popcount of the next busy vector, registered with it.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_d = pend_d + {{ABITS{1'b0}}, busy_d[i]};
        end
    end

    // Data storage: register 0 is never written, so it stays at its reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regb_q[i] <= '0;
            end
        end else if (wr_en) begin
            regb_q[wa3] <= wd3;
        end
    end

    // Scoreboard state: busy bits and their registered count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    // Read port 1: stored value, or the in-flight write when forwarding is on.
    always_comb begin
        rd1   = regb_q[ra1];
        busy1 = busy_q[ra1];
        if (BYPASS && wr_en && (wa3 == ra1)) begin
            rd1   = wd3;
            busy1 = 1'b0;
        end
    end

    // Read port 2: identical behaviour to port 1.
    always_comb begin
        rd2   = regb_q[ra2];
        busy2 = busy_q[ra2];
        if (BYPASS && wr_en && (wa3 == ra2)) begin
            rd2   = wd3;
            busy2 = 1'b0;
        end
    end

    assign pend_cnt = pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives a bypassing and a non-bypassing register file with the
// same directed vectors; expected responses are queued by the stimulus and
// compared by an independent monitor process.
module tb_regfile_sb;

    logic       clk;
    logic       reset;
    logic       we3;
    logic [3:0] wa3;
    logic [7:0] wd3;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic       iss;
    logic [3:0] ia;

    logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic       a_busy1, a_busy2, b_busy1, b_busy2;
    logic [4:0] a_pend, b_pend;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        int         inst;
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic       b1;
        logic       b2;
        logic [4:0] pend;
    } exp_t;

    exp_t exp_q[$];

    regfile_sb #(.WIDTH(8), .ABITS(4), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2),
        .iss(iss), .ia(ia), .busy1(a_busy1), .busy2(a_busy2), .pend_cnt(a_pend)
    );

    regfile_sb #(.WIDTH(8), .ABITS(4), .BYPASS(1'b0)) u_nob (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
        .iss(iss), .ia(ia), .busy1(b_busy1), .busy2(b_busy2), .pend_cnt(b_pend)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic cmp(string nm, string field, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
        end
    endtask

    // Monitor: pops each queued expectation and compares it to the live outputs.
    initial begin
        exp_t e;
        forever begin
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.inst == 0) begin
                    cmp(e.name, "byp.rd1",  a_rd1, e.rd1);
                    cmp(e.name, "byp.rd2",  a_rd2, e.rd2);
                    cmp(e.name, "byp.busy1", {7'd0, a_busy1}, {7'd0, e.b1});
                    cmp(e.name, "byp.busy2", {7'd0, a_busy2}, {7'd0, e.b2});
                    cmp(e.name, "byp.pend", {3'd0, a_pend}, {3'd0, e.pend});
                end else begin
                    cmp(e.name, "nob.rd1",  b_rd1, e.rd1);
                    cmp(e.name, "nob.rd2",  b_rd2, e.rd2);
                    cmp(e.name, "nob.busy1", {7'd0, b_busy1}, {7'd0, e.b1});
                    cmp(e.name, "nob.busy2", {7'd0, b_busy2}, {7'd0, e.b2});
                    cmp(e.name, "nob.pend", {3'd0, b_pend}, {3'd0, e.pend});
                end
            end
        end
    end

    task automatic push(string nm, int inst, logic [7:0] r1, logic [7:0] r2,
                        logic b1, logic b2, logic [4:0] p);
        exp_t e;
        e.name = nm; e.inst = inst; e.rd1 = r1; e.rd2 = r2;
        e.b1 = b1; e.b2 = b2; e.pend = p;
        exp_q.push_back(e);
    endtask

    task automatic drain(string nm);
        for (int k = 0; k < 4; k++) begin
            if (exp_q.size() == 0) break;
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=%0d_pending required=0_pending", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Same expectation for both instances.
    task automatic both(string nm, logic [7:0] r1, logic [7:0] r2,
                        logic b1, logic b2, logic [4:0] p);
        #1;
        push(nm, 0, r1, r2, b1, b2, p);
        push(nm, 1, r1, r2, b1, b2, p);
        drain(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        we3 = 1'b0; wa3 = 4'd0; wd3 = 8'd0; iss = 1'b0; ia = 4'd0;
    endtask

    task automatic wr(logic [3:0] a, logic [7:0] d);
        idle();
        we3 = 1'b1; wa3 = a; wd3 = d;
        tick();
        idle();
    endtask

    task automatic issue(logic [3:0] a);
        idle();
        iss = 1'b1; ia = a;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        ra1 = 4'd0; ra2 = 4'd0;
        both("reset_init", 8'h00, 8'h00, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        reset = 1'b0;

        // Async reset clears state without any clock edge.
        wr(4'd3, 8'hAA);
        ra1 = 4'd3;
        both("r3_written", 8'hAA, 8'h00, 1'b0, 1'b0, 5'd0);
        reset = 1'b1;
        both("async_reset", 8'h00, 8'h00, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        reset = 1'b0;

        // Normal write plus ignored write to r0.
        wr(4'd7, 8'h5C);
        wr(4'd0, 8'hFF);
        ra1 = 4'd7; ra2 = 4'd0;
        both("rd_r7_r0", 8'h5C, 8'h00, 1'b0, 1'b0, 5'd0);
        ra1 = 4'd0; ra2 = 4'd7;
        both("rd_r0_r7", 8'h00, 8'h5C, 1'b0, 1'b0, 5'd0);

        // r5 issued and written on one edge: data lands, busy stays set.
        idle();
        we3 = 1'b1; wa3 = 4'd5; wd3 = 8'h21; iss = 1'b1; ia = 4'd5;
        tick();
        idle();
        ra1 = 4'd5; ra2 = 4'd5;
        both("r5_collide", 8'h21, 8'h21, 1'b1, 1'b1, 5'd1);

        // Forwarding: only the bypassing instance sees the pending write.
        we3 = 1'b1; wa3 = 4'd5; wd3 = 8'h3E; ra2 = 4'd7;
        #1;
        push("bypass", 0, 8'h3E, 8'h5C, 1'b0, 1'b0, 5'd1);
        push("bypass", 1, 8'h21, 8'h5C, 1'b1, 1'b0, 5'd1);
        drain("bypass");
        tick();
        idle();
        ra2 = 4'd5;
        both("r5_after_wr", 8'h3E, 8'h3E, 1'b0, 1'b0, 5'd0);

        // Scoreboard on r4.
        ra1 = 4'd4; ra2 = 4'd0;
        issue(4'd4);
        both("iss_r4", 8'h00, 8'h00, 1'b1, 1'b0, 5'd1);
        issue(4'd4);
        both("iss_r4_again", 8'h00, 8'h00, 1'b1, 1'b0, 5'd1);
        wr(4'd4, 8'h11);
        both("wr_r4", 8'h11, 8'h00, 1'b0, 1'b0, 5'd0);

        // Collision on already-busy r9.
        ra1 = 4'd9; ra2 = 4'd9;
        issue(4'd9);
        both("iss_r9", 8'h00, 8'h00, 1'b1, 1'b1, 5'd1);
        we3 = 1'b1; wa3 = 4'd9; wd3 = 8'h42; iss = 1'b1; ia = 4'd9;
        tick();
        idle();
        both("r9_collide", 8'h42, 8'h42, 1'b1, 1'b1, 5'd1);

        // Write and issue to different registers on one edge.
        we3 = 1'b1; wa3 = 4'd9; wd3 = 8'h43; iss = 1'b1; ia = 4'd10;
        tick();
        idle();
        ra2 = 4'd10;
        both("wr9_iss10", 8'h43, 8'h00, 1'b0, 1'b1, 5'd1);

        // Saturation: every nonzero register pending.
        for (int i = 1; i < 16; i++) begin
            issue(i[3:0]);
        end
        ra1 = 4'd15; ra2 = 4'd1;
        both("all_busy", 8'h00, 8'h00, 1'b1, 1'b1, 5'd15);
        issue(4'd0);
        ra1 = 4'd0;
        both("iss_r0", 8'h00, 8'h00, 1'b0, 1'b1, 5'd15);
        for (int i = 1; i < 16; i++) begin
            wr(i[3:0], i[7:0]);
        end
        ra1 = 4'd15; ra2 = 4'd1;
        both("all_clear", 8'h0F, 8'h01, 1'b0, 1'b0, 5'd0);

        // Reset held across an edge overrides a write and an issue.
        reset = 1'b1;
        we3 = 1'b1; wa3 = 4'd2; wd3 = 8'h77; iss = 1'b1; ia = 4'd2;
        tick();
        idle();
        ra1 = 4'd2;
        both("reset_override", 8'h00, 8'h00, 1'b0, 1'b0, 5'd0);
        reset = 1'b0;
        wr(4'd2, 8'h66);
        both("post_reset_wr", 8'h66, 8'h00, 1'b0, 1'b0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
